// File: rtl/chip8_alu_seq.sv
// chip8_alu_seq
// Registered CHIP-8 ALU. It executes the 8XYn arithmetic/logic operations in
// one cycle, and the FX33 binary-to-BCD conversion as a WIDTH-cycle
// double-dabble sequence.
//
// Ports:
//   clk      rising-edge clock
//   reset_n  synchronous active-low reset
//   start    request; accepted on an edge where start=1 and ready=1
//   op       operation code, sampled at acceptance
//   x, y     operands VX / VY, sampled at acceptance
//   ready    high when idle and able to accept a request
//   done     one-cycle pulse; result/flag/bcd are valid from this cycle
//   result   registered result
//   flag     registered VF value
//   bcd      registered BCD of x (digit 0 in bits [3:0]); updated only by op 8
module chip8_alu_seq #(
  parameter int WIDTH  = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  start,
  input  logic [3:0]            op,
  input  logic [WIDTH-1:0]      x,
  input  logic [WIDTH-1:0]      y,
  output logic                  ready,
  output logic                  done,
  output logic [WIDTH-1:0]      result,
  output logic                  flag,
  output logic [4*DIGITS-1:0]   bcd
);

  localparam int BW = 4 * DIGITS;
  localparam int SW = BW + WIDTH;
  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t            state_q, state_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic [WIDTH-1:0]  result_q, result_d;
  logic              flag_q, flag_d;
  logic [BW-1:0]     bcd_q, bcd_d;
  logic [SW-1:0]     sr_q, sr_d;
  logic [CW-1:0]     count_q, count_d;
  logic [WIDTH-1:0]  x_q, x_d;

  logic [WIDTH:0]    sum_s;
  logic [WIDTH:0]    diff_xy_s;
  logic [WIDTH:0]    diff_yx_s;
  logic [WIDTH-1:0]  alu_result_s;
  logic              alu_flag_s;
  logic [SW-1:0]     sr_shift_s;

  // Double-dabble correction: every BCD nibble >= 5 gets +3 before the shift.
  function automatic logic [BW-1:0] dabble_adjust(input logic [BW-1:0] d);
    logic [BW-1:0] r;
    r = d;
    for (int i = 0; i < DIGITS; i++) begin
      if (r[4*i +: 4] >= 4'd5) begin
        r[4*i +: 4] = r[4*i +: 4] + 4'd3;
      end else begin
        r[4*i +: 4] = r[4*i +: 4];
      end
    end
    return r;
  endfunction

  // Single-cycle 8XYn datapath; the extra top bit of each sum/difference is the carry/borrow.
  always_comb begin
    sum_s        = {1'b0, x} + {1'b0, y};
    diff_xy_s    = {1'b0, x} - {1'b0, y};
    diff_yx_s    = {1'b0, y} - {1'b0, x};
    alu_result_s = x;
    alu_flag_s   = 1'b0;
    case (op)
      4'h0: alu_result_s = y;
      4'h1: alu_result_s = x | y;
      4'h2: alu_result_s = x & y;
      4'h3: alu_result_s = x ^ y;
      4'h4: begin
        alu_result_s = sum_s[WIDTH-1:0];
        alu_flag_s   = sum_s[WIDTH];
      end
      4'h5: begin
        alu_result_s = diff_xy_s[WIDTH-1:0];
        alu_flag_s   = ~diff_xy_s[WIDTH];
      end
      4'h6: begin
        alu_result_s = {1'b0, x[WIDTH-1:1]};
        alu_flag_s   = x[0];
      end
      4'h7: begin
        alu_result_s = diff_yx_s[WIDTH-1:0];
        alu_flag_s   = ~diff_yx_s[WIDTH];
      end
      4'hE: begin
        alu_result_s = {x[WIDTH-2:0], 1'b0};
        alu_flag_s   = x[WIDTH-1];
      end
      default: begin
        alu_result_s = x;
        alu_flag_s   = 1'b0;
      end
    endcase
  end

  // One double-dabble step on the {bcd, bin} shift register.
  always_comb begin
    sr_shift_s = {dabble_adjust(sr_q[SW-1:WIDTH]), sr_q[WIDTH-1:0]} << 1;
  end

  // Next-state logic for the IDLE/RUN sequencer and all registered outputs.
  always_comb begin
    state_d  = state_q;
    ready_d  = ready_q;
    done_d   = 1'b0;
    result_d = result_q;
    flag_d   = flag_q;
    bcd_d    = bcd_q;
    sr_d     = sr_q;
    count_d  = count_q;
    x_d      = x_q;
    case (state_q)
      ST_IDLE: begin
        ready_d = 1'b1;
        if (start) begin
          if (op == 4'h8) begin
            sr_d    = {{BW{1'b0}}, x};
            x_d     = x;
            count_d = CW'(WIDTH);
            state_d = ST_RUN;
            ready_d = 1'b0;
          end else begin
            result_d = alu_result_s;
            flag_d   = alu_flag_s;
            done_d   = 1'b1;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_RUN: begin
        sr_d    = sr_shift_s;
        count_d = count_q - CW'(1);
        // Last shift: the conversion result is taken straight from the shifted value.
        if (count_q == CW'(1)) begin
          bcd_d    = sr_shift_s[SW-1:WIDTH];
          result_d = x_q;
          flag_d   = 1'b0;
          done_d   = 1'b1;
          state_d  = ST_IDLE;
          ready_d  = 1'b1;
        end else begin
          ready_d  = 1'b0;
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      ready_q  <= 1'b1;
      done_q   <= 1'b0;
      result_q <= {WIDTH{1'b0}};
      flag_q   <= 1'b0;
      bcd_q    <= {BW{1'b0}};
      sr_q     <= {SW{1'b0}};
      count_q  <= {CW{1'b0}};
      x_q      <= {WIDTH{1'b0}};
    end else begin
      state_q  <= state_d;
      ready_q  <= ready_d;
      done_q   <= done_d;
      result_q <= result_d;
      flag_q   <= flag_d;
      bcd_q    <= bcd_d;
      sr_q     <= sr_d;
      count_q  <= count_d;
      x_q      <= x_d;
    end
  end

  assign ready  = ready_q;
  assign done   = done_q;
  assign result = result_q;
  assign flag   = flag_q;
  assign bcd    = bcd_q;

endmodule

// File: tb/tb_chip8_alu_seq.sv
// Directed plus randomized bench for chip8_alu_seq (WIDTH=8 and WIDTH=12 instances).
module tb_chip8_alu_seq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [3:0]  op;
  logic [7:0]  x, y;
  logic        ready, done, flag;
  logic [7:0]  result;
  logic [11:0] bcd;

  logic        start12;
  logic [3:0]  op12;
  logic [11:0] x12, y12;
  logic        ready12, done12, flag12;
  logic [11:0] result12;
  logic [15:0] bcd12;

  int vectors = 0;
  int fails   = 0;
  int exp_bcd = 0;

  chip8_alu_seq #(.WIDTH(8), .DIGITS(3)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .op(op), .x(x), .y(y),
    .ready(ready), .done(done), .result(result), .flag(flag), .bcd(bcd)
  );

  chip8_alu_seq #(.WIDTH(12), .DIGITS(4)) dut12 (
    .clk(clk), .reset_n(reset_n), .start(start12), .op(op12), .x(x12), .y(y12),
    .ready(ready12), .done(done12), .result(result12), .flag(flag12), .bcd(bcd12)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference 8XYn semantics for 8-bit registers, using plain integer arithmetic.
  function automatic void ref_alu(input int o, input int a, input int b, output int r, output int f);
    r = a;
    f = 0;
    case (o)
      0: r = b;
      1: r = a | b;
      2: r = a & b;
      3: r = a ^ b;
      4: begin r = (a + b) % 256; f = (a + b > 255) ? 1 : 0; end
      5: begin r = (a - b + 256) % 256; f = (a >= b) ? 1 : 0; end
      6: begin r = a / 2; f = a % 2; end
      7: begin r = (b - a + 256) % 256; f = (b >= a) ? 1 : 0; end
      14: begin r = (a * 2) % 256; f = a / 128; end
      default: begin r = a; f = 0; end
    endcase
  endfunction

  // Decimal digits packed as nibbles.
  function automatic int ref_bcd(input int v);
    int r = 0;
    for (int d = 0; d < 8; d++) begin
      r = r | ((v % 10) << (4 * d));
      v = v / 10;
    end
    return r;
  endfunction

  task automatic run_single(input int o, input int a, input int b, input int er, input int ef);
    check("ready_before", 32'(ready), 32'd1);
    start = 1'b1; op = 4'(o); x = 8'(a); y = 8'(b);
    step();
    start = 1'b0;
    check($sformatf("done_op%0h", o), 32'(done), 32'd1);
    check($sformatf("result_op%0h", o), 32'(result), 32'(er));
    check($sformatf("flag_op%0h", o), 32'(flag), 32'(ef));
    check($sformatf("bcd_hold_op%0h", o), 32'(bcd), 32'(exp_bcd));
    step();
    check("done_pulse_end", 32'(done), 32'd0);
  endtask

  task automatic run_bcd(input int a, input int eb, input bit pulse);
    int cnt = 0;
    check("ready_before_bcd", 32'(ready), 32'd1);
    start = 1'b1; op = 4'h8; x = 8'(a); y = 8'h00;
    step();
    start = 1'b0;
    while (ready == 1'b0 && cnt < 40) begin
      cnt++;
      if (done !== 1'b0) check("done_early", 32'(done), 32'd0);
      if (pulse && cnt == 3) begin start = 1'b1; op = 4'h4; x = 8'h11; y = 8'h22; end
      if (cnt == 4) start = 1'b0;
      step();
    end
    exp_bcd = eb;
    check("bcd_busy_cycles", 32'(cnt), 32'd8);
    check("bcd_done", 32'(done), 32'd1);
    check("bcd_value", 32'(bcd), 32'(eb));
    check("bcd_result", 32'(result), 32'(a));
    check("bcd_flag", 32'(flag), 32'd0);
    step();
    check("bcd_done_end", 32'(done), 32'd0);
  endtask

  initial begin
    int r, f, o, a, b, cnt;
    int ops[12] = '{0, 1, 2, 3, 4, 5, 6, 7, 14, 8, 9, 10};
    reset_n = 1'b0; start = 1'b0; op = 4'h0; x = 8'h00; y = 8'h00;
    start12 = 1'b0; op12 = 4'h0; x12 = 12'h000; y12 = 12'h000;
    step(); step();
    check("rst_ready", 32'(ready), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_result", 32'(result), 32'd0);
    check("rst_flag", 32'(flag), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    reset_n = 1'b1;
    step();

    // Back-to-back adds.
    start = 1'b1; op = 4'h4; x = 8'hF0; y = 8'h20;
    step();
    op = 4'h4; x = 8'h01; y = 8'h02;
    check("b2b_done1", 32'(done), 32'd1);
    check("b2b_result1", 32'(result), 32'h10);
    check("b2b_flag1", 32'(flag), 32'd1);
    step();
    start = 1'b0;
    check("b2b_done2", 32'(done), 32'd1);
    check("b2b_result2", 32'(result), 32'h03);
    check("b2b_flag2", 32'(flag), 32'd0);
    step();
    check("b2b_done_end", 32'(done), 32'd0);

    run_single(5, 8'h10, 8'h10, 8'h00, 1);
    run_single(5, 8'h03, 8'h05, 8'hFE, 0);
    run_single(7, 8'h05, 8'h03, 8'hFE, 0);
    run_single(6, 8'h81, 8'h00, 8'h40, 1);
    run_single(14, 8'h81, 8'h00, 8'h02, 1);
    run_single(1, 8'hC3, 8'h5A, 8'hDB, 0);
    run_single(2, 8'hC3, 8'h5A, 8'h42, 0);
    run_single(3, 8'hC3, 8'h5A, 8'h99, 0);
    run_single(0, 8'hC3, 8'h5A, 8'h5A, 0);

    run_bcd(8'hFF, 12'h255, 1'b0);
    run_single(9, 8'h77, 8'h00, 8'h77, 0);
    run_bcd(8'h00, 12'h000, 1'b0);
    run_bcd(8'h64, 12'h100, 1'b1);

    // Reset in the middle of a conversion.
    start = 1'b1; op = 4'h8; x = 8'hC8; y = 8'h00;
    step();
    start = 1'b0;
    step(); step(); step();
    reset_n = 1'b0;
    step();
    reset_n = 1'b1;
    exp_bcd = 0;
    check("mid_rst_ready", 32'(ready), 32'd1);
    check("mid_rst_done", 32'(done), 32'd0);
    check("mid_rst_bcd", 32'(bcd), 32'd0);
    check("mid_rst_result", 32'(result), 32'd0);
    check("mid_rst_flag", 32'(flag), 32'd0);
    for (int i = 0; i < 12; i++) begin
      step();
      check("mid_rst_no_done", 32'(done), 32'd0);
    end

    // 12-bit instance.
    start12 = 1'b1; op12 = 4'h8; x12 = 12'hFFF;
    step();
    start12 = 1'b0;
    cnt = 0;
    while (ready12 == 1'b0 && cnt < 40) begin
      cnt++;
      step();
    end
    check("w12_busy", 32'(cnt), 32'd12);
    check("w12_done", 32'(done12), 32'd1);
    check("w12_bcd", 32'(bcd12), 32'h4095);
    check("w12_result", 32'(result12), 32'hFFF);

    // Randomized operations against the reference model.
    for (int i = 0; i < 40; i++) begin
      o = ops[$urandom_range(0, 11)];
      a = int'($urandom_range(0, 255));
      b = int'($urandom_range(0, 255));
      if (o == 8) begin
        run_bcd(a, ref_bcd(a), 1'($urandom_range(0, 1)));
      end else begin
        ref_alu(o, a, b, r, f);
        run_single(o, a, b, r, f);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
